// File: rtl/seven_seg_scanner.sv
// Multiplexed BCD seven-segment scanner; display data swaps only at frame boundaries. Optional LEADING_ZERO_BLANK_EN.
// Latency: an_out/seg_out lag the digit index by one cycle; new data appears the cycle after frame_done.
// Backpressure: none; load is a strobe, and the last value loaded before a boundary wins.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick;
    logic [3:0]            cur_dig;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  upper_zero;
`endif

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick         = (presc_q == PRESC_LAST);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (tick) begin
            if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (frame_done_q) begin
            // A load landing on the boundary bypasses the pending register.
            if (load) begin
                disp_d     = bcd_in;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                disp_d     = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (load) begin
            pend_d     = bcd_in;
            pend_vld_d = 1'b1;
        end

        // Decode from disp_d so digit 0 of a new frame already shows the new data.
        cur_dig = '0;
        an_d    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_dig = disp_d[4*k +: 4];
                an_d[k] = 1'b0;
            end
        end
        seg_d = seg_enc(cur_dig);

`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (disp_d[4*k +: 4] == 4'd0);
            if ((idx_q == IW'(k)) && upper_zero) begin
                an_d[k] = 1'b1;
                seg_d   = 7'b1111111;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=3, REFRESH_DIV=4.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic [11:0] bcd_in;
    logic        load;
    logic [2:0]  an_out;
    logic [6:0]  seg_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(.NUM_DIGITS(3), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0:    exp_seg = 7'b1000000;
            4'd1:    exp_seg = 7'b1111001;
            4'd2:    exp_seg = 7'b0100100;
            4'd3:    exp_seg = 7'b0110000;
            4'd4:    exp_seg = 7'b0011001;
            4'd5:    exp_seg = 7'b0010010;
            4'd6:    exp_seg = 7'b0000010;
            4'd7:    exp_seg = 7'b1111000;
            4'd8:    exp_seg = 7'b0000000;
            4'd9:    exp_seg = 7'b0010000;
            default: exp_seg = 7'b1111111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("frame_done_seen", {11'd0, frame_done}, 12'd1);
    endtask

    // Called in a frame_done cycle; checks the 12 cycles of the next frame.
    // Optional load pulses are issued after step ld_at / ld2_at (sampled on the following edge).
    task automatic check_frame(input string tag, input logic [11:0] dat,
                               input int ld_at, input logic [11:0] ld_dat,
                               input int ld2_at, input logic [11:0] ld2_dat);
        for (int i = 0; i < 12; i++) begin
            int         slot;
            logic [3:0] d;
            logic [2:0] ea;
            logic       blank;
            slot  = i / 4;
            d     = dat[4*slot +: 4];
            ea    = ~(3'b001 << slot);
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (slot == 1 && dat[11:4] == 8'd0) || (slot == 2 && dat[11:8] == 4'd0);
            if (blank) ea = 3'b111;
`endif
            step();
            load = 1'b0;
            if (i == ld_at) begin
                load   = 1'b1;
                bcd_in = ld_dat;
            end
            if (i == ld2_at) begin
                load   = 1'b1;
                bcd_in = ld2_dat;
            end
            chk({tag, "_an"}, {9'd0, an_out}, {9'd0, ea});
            if (!blank) chk({tag, "_seg"}, {5'd0, seg_out}, {5'd0, exp_seg(d)});
            chk({tag, "_fd"}, {11'd0, frame_done}, {11'd0, (i == 11)});
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = 12'h000;

        // Reset state
        step();
        step();
        step();
        chk("rst_an", {9'd0, an_out}, 12'h007);
        chk("rst_seg", {5'd0, seg_out}, 12'h07F);
        chk("rst_fd", {11'd0, frame_done}, 12'd0);

        rst = 1'b0;
        step();
        chk("post_rst_an", {9'd0, an_out}, 12'h006);
        chk("post_rst_seg", {5'd0, seg_out}, 12'h040);

        // Scenario 1: pending load of 123 shows after the first boundary
        load   = 1'b1;
        bcd_in = 12'h123;
        step();
        load = 1'b0;
        wait_fd();
        check_frame("s1", 12'h123, -1, 12'h000, -1, 12'h000);

        // Scenario 3 with last-wins: two loads mid-frame, current frame unchanged
        check_frame("s3_hold", 12'h123, 2, 12'h999, 6, 12'h456);
        // Scenario 2 load issued during the 456 frame
        check_frame("s3_new", 12'h456, 4, 12'h1A5, -1, 12'h000);
        check_frame("s2", 12'h1A5, -1, 12'h000, -1, 12'h000);

        // Scenario 4: load exactly in the frame_done cycle
        load   = 1'b1;
        bcd_in = 12'h789;
        check_frame("s4", 12'h789, -1, 12'h000, -1, 12'h000);
        // Pending flag must be clear: stale pending 1A5 must not reappear
        check_frame("s4_flag", 12'h789, 3, 12'h007, -1, 12'h000);

        // Scenario 6: leading zeros
        check_frame("s6", 12'h007, -1, 12'h000, -1, 12'h000);

        // Scenario 5: reset mid-scan with a pending load
        step();
        step();
        step();
        load   = 1'b1;
        bcd_in = 12'h321;
        step();
        load = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_an", {9'd0, an_out}, 12'h007);
        chk("s5_seg", {5'd0, seg_out}, 12'h07F);
        chk("s5_fd", {11'd0, frame_done}, 12'd0);
        step();
        chk("s5_rel_an", {9'd0, an_out}, 12'h006);
        chk("s5_rel_seg", {5'd0, seg_out}, 12'h040);
        wait_fd();
        check_frame("s5_discard", 12'h000, -1, 12'h000, -1, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, and all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter NUM_DIGITS, default 3: number of multiplexed digits; legal range 2..8.
REQ-003 Parameter REFRESH_DIV, default 50000: clk cycles each digit stays lit; legal range >= 2.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port bcd_in  input  4*NUM_DIGITS  BCD digits; digit k is bcd_in[4k+3:4k], and digit 0 is the least significant.
REQ-007 Port load  input  1  single-cycle strobe that captures bcd_in.
REQ-008 Port an_out  output  NUM_DIGITS  active-low anode enables; bit k drives digit k.
REQ-009 Port seg_out  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 Port frame_done  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Function
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; its terminal count is the digit tick.
REQ-012 On each digit tick, the digit index SHALL increment. At index NUM_DIGITS-1 it SHALL wrap to 0 and assert frame_done for exactly that cycle.
REQ-013 On load=1, the block SHALL capture bcd_in into a pending register and set a pending flag.
REQ-014 The display register SHALL update only at a frame boundary, defined as the cycle in which frame_done is asserted, and only when the pending flag is set. The flag SHALL clear at that update, so the displayed data never tears mid-frame.
REQ-015 If load coincides with a frame boundary, the display register SHALL take bcd_in from that same cycle directly, and the pending flag SHALL end clear.
REQ-016 A later load before the boundary SHALL overwrite the pending value, so the last value loaded wins.
REQ-017 an_out and seg_out SHALL be registered and SHALL reflect the current index one cycle later.
REQ-018 Exactly one an_out bit SHALL be low at a time, except when blanked by reset or by REQ-025.
REQ-019 Segment encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Digit codes 10..15 SHALL drive seg_out=1111111 (blank) while that digit is active; the anode is still driven.
REQ-021 Index and prescaler widths SHALL be derived with $clog2 and SHALL never exceed their maximum count.

Reset
REQ-022 While rst=1, the block SHALL hold: prescaler=0, index=0, display=0, pending register=0, pending flag=0, an_out all ones, seg_out=1111111, frame_done=0.
REQ-023 In the first cycle after rst falls, the block SHALL drive an_out with bit 0 low and seg_out=1000000.
REQ-024 If rst is asserted mid-scan or while load is pending, the block SHALL discard the pending data and return to the reset state on the next edge.

Configuration
REQ-025 With LEADING_ZERO_BLANK_EN defined, the block SHALL hold the anode high for every zero digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, the block SHALL light all digits, leading zeros included; timing is identical in both builds.

Verification
REQ-027 Scenario 1 (NUM_DIGITS=3, REFRESH_DIV=4): release reset, pulse load with 12'h123, and wait one frame. After the update, an_out SHALL cycle 110, 101, 011, holding each for 4 cycles, with seg_out 0110000, 0100100, 1111001 respectively.
REQ-028 Scenario 2: load 12'h1A5. While digit 1 is active, an_out SHALL be 101 and seg_out SHALL be 1111111.
REQ-029 Scenario 3: while 12'h123 is displayed, load 12'h456 mid-frame. The remaining digits of the current frame SHALL still show 1,2,3; 4,5,6 SHALL appear from the cycle after frame_done.
REQ-030 Scenario 4: pulse load exactly in the frame_done cycle with 12'h789. The following frame SHALL display 7,8,9, and the pending flag SHALL be 0.
REQ-031 Scenario 5: assert rst for one cycle mid-scan. The next cycle SHALL show an_out=111, seg_out=1111111, frame_done=0, with the pending data discarded.
REQ-032 Scenario 6: load 12'h007. With LEADING_ZERO_BLANK_EN, an_out SHALL be 111 during the digit 1 and digit 2 slots. Without it, those slots SHALL show an_out=101 and 011 with seg_out=1000000.
